fdc_mem_arb: RTL and testbench
==============================

# fdc_mem_arb

Two-port read arbiter for the floppy-image media memory. It shares one 16-bit read port between two media requesters, typically two FDC emulation instances or an FDC plus a boot loader. Each requester port has a one-word read cache, so sequential byte fetches that fall in the same 16-bit word skip the memory. A timeout guards against a memory that never acknowledges.

## Interface
Parameters:
- FIXED_PRI, 0, 0 = round-robin between ports; 1 = port 0 always wins a tie
- TMO_CYC, 255, number of WAIT cycles without mem_ack before abort (1..255)
- BUSFREE, 16'hFFFF, data returned on timeout

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- req0 / req1  in  1  read request, level; held with stable address until ack
- addr0 / addr1  in  20  byte address; word selected by [19:1]
- ack0 / ack1  out  1  one-cycle pulse, rdataN/errN valid
- rdata0 / rdata1  out  16  returned word, held until next ackN
- err0 / err1  out  1  valid with ackN; 1 = timed out, data = BUSFREE
- inv  in  1  pulse; clears both cache valid bits
- mem_req  out  1  memory read strobe, held until mem_ack or timeout
- mem_addr  out  20  registered address, stable while mem_req=1
- mem_rdata  in  16  memory data, sampled when mem_ack=1
- mem_ack  in  1  memory data valid
- busy  out  1  1 in any state except IDLE

## Operation
- States: IDLE, LOOK, WAIT, DONE.
- IDLE:
  - no request: stay in IDLE.
  - else grant one port, latch its address into mem_addr, go to LOOK.
  - tie handling: FIXED_PRI=1 gives port 0. Otherwise the port not granted last wins; the last-grant register resets to 1, so port 0 wins the first tie.
- LOOK:
  - cache hit (granted port valid and tag == addr[19:1]): load cache data, err=0, go to DONE; mem_req stays 0.
  - miss: mem_req<=1, timeout counter<=0, go to WAIT.
- WAIT:
  - mem_ack=1: capture mem_rdata into that port's rdata and cache. Set tag=addr[19:1], valid=1, err=0. mem_req<=0, go to DONE.
  - otherwise: counter increments (8-bit). When counter==TMO_CYC-1 without ack: mem_req<=0, rdata=BUSFREE, err=1, cache untouched, go to DONE.
- DONE: ackN=1 for the granted port for exactly one cycle, update last-grant, go to IDLE.
- A mem_ack seen outside WAIT is ignored.
- inv has priority over a same-cycle cache fill: the valid bit ends up 0.
- inv does not abort a transaction in progress.
- rdataN, errN, and the cache of the non-granted port never change.
- A requester must drop req in the cycle after it sees ack. If req is still high in IDLE, a new transaction starts.

## Timing
- Reset values: state IDLE, ack0/1=0, err0/1=0, rdata0/1=16'h0000, mem_req=0, mem_addr=0, busy=0, cache valid=0, last-grant=1.
- Reset asserted mid-transaction returns everything to reset values immediately. No ack is issued for the aborted request.
- Hit: req seen at edge n (IDLE), LOOK at n+1, ack high during cycle n+2. Latency is 2 cycles.
- Miss: mem_req high from cycle n+2. If mem_ack arrives at cycle n+2+k, ack is high during cycle n+3+k.
- Timeout: mem_req stays high exactly TMO_CYC cycles, then drops. ack with err=1 follows one cycle later.
- Back-to-back: a new grant is possible in the IDLE cycle right after DONE. Minimum spacing between acks is 3 cycles.
- busy is high from LOOK through DONE.

## Test plan
- Hit/miss pair: req0 at addr 20'h00100, mem_ack 2 cycles after mem_req with 16'hA55A -> ack0 with rdata0=16'hA55A, err0=0. Then req0 at addr 20'h00101 -> ack0 2 cycles after req, rdata0=16'hA55A, mem_req never rises.
- Round-robin: req0 and req1 held continuously at different words -> grants alternate 0,1,0,1; first ack is ack0. With FIXED_PRI=1, repeat with req0 re-asserted after each ack0 -> req1 is never served while req0 is pending.
- Timeout: TMO_CYC=8, mem_ack tied 0 -> mem_req high exactly 8 cycles, then ack1 with rdata1=16'hFFFF, err1=1. A repeat request to the same address misses again.
- Invalidate: fill port 0 at addr 20'h00200, pulse inv, re-request 20'h00201 -> mem_req issued, no cache hit. Also pulse inv in the same cycle as a fill -> the next same-word access still misses.
- Reset mid-WAIT: assert rst while mem_req=1 -> mem_req=0, busy=0, no ack0/ack1 issued, next request misses.
- Stray ack: pulse mem_ack while in IDLE -> no ack, rdata unchanged, cache unchanged.

Source files
------------

// File: rtl/fdc_mem_arb.sv
// -----------------------------------------------------------------------------
// fdc_mem_arb
//
// Shares one 16-bit media-memory read port between two requesters.
// - Each requester has a one-word read cache, so byte fetches that land in the
//   same 16-bit word are answered without a memory cycle.
// - A WAIT-state timeout stops a silent memory from hanging a requester.
//
// Ports:
//   clk, rst           clock (rising edge), asynchronous active-high reset
//   req0/req1          level read requests; the address is held until ack
//   addr0/addr1        byte addresses; the word is selected by [19:1]
//   ack0/ack1          one-cycle completion pulses
//   rdata0/rdata1      returned words; held until the next ack of that port
//   err0/err1          valid with ack; 1 = timed out, data = BUSFREE
//   inv                pulse; clears both cache valid bits
//   mem_req            memory read strobe; held until mem_ack or timeout
//   mem_addr           registered request address
//   mem_rdata/mem_ack  memory return data and its valid strobe
//   busy               high whenever the arbiter is not in IDLE
// -----------------------------------------------------------------------------
module fdc_mem_arb #(
    parameter logic        FIXED_PRI = 1'b0,
    parameter logic [7:0]  TMO_CYC   = 8'd255,
    parameter logic [15:0] BUSFREE   = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic [19:0] addr0,
    output logic        ack0,
    output logic [15:0] rdata0,
    output logic        err0,
    input  logic        req1,
    input  logic [19:0] addr1,
    output logic        ack1,
    output logic [15:0] rdata1,
    output logic        err1,
    input  logic        inv,
    output logic        mem_req,
    output logic [19:0] mem_addr,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE = 2'd0, LOOK = 2'd1, WAIT = 2'd2, DONE = 2'd3} state_t;

    state_t      state_reg, state_next;
    logic        gnt_reg, gnt_next;
    logic        last_reg;
    logic [19:0] mem_addr_reg;
    logic        mem_req_reg;
    logic [7:0]  cnt_reg;

    logic        grant_en, hit_en, miss_en, fill_en, tmo_en, done_en;
    logic        cache_hit;

    logic [1:0]  req_vec;
    logic [19:0] addr_vec  [2];
    logic [1:0]  valid_vec;
    logic [1:0]  ack_vec;
    logic [1:0]  err_vec;
    logic [18:0] tag_vec   [2];
    logic [15:0] cdata_vec [2];
    logic [15:0] rdata_vec [2];

    assign req_vec     = {req1, req0};
    assign addr_vec[0] = addr0;
    assign addr_vec[1] = addr1;

    // The granted address is already latched by LOOK, so compare against it.
    assign cache_hit = valid_vec[gnt_reg] && (tag_vec[gnt_reg] == mem_addr_reg[19:1]);

    // Next-state and per-cycle control strobes.
    always_comb begin
        state_next = state_reg;
        gnt_next   = gnt_reg;
        grant_en   = 1'b0;
        hit_en     = 1'b0;
        miss_en    = 1'b0;
        fill_en    = 1'b0;
        tmo_en     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (|req_vec) begin
                    grant_en   = 1'b1;
                    state_next = LOOK;
                    if (req_vec == 2'b11) begin
                        // Tie: fixed mode favours port 0, otherwise the port
                        // that did not win last time.
                        gnt_next = FIXED_PRI ? 1'b0 : ~last_reg;
                    end else begin
                        gnt_next = req_vec[1];
                    end
                end
            end
            LOOK: begin
                if (cache_hit) begin
                    hit_en     = 1'b1;
                    state_next = DONE;
                end else begin
                    miss_en    = 1'b1;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (mem_ack) begin
                    fill_en    = 1'b1;
                    state_next = DONE;
                end else if (cnt_reg == TMO_CYC - 8'd1) begin
                    tmo_en     = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign done_en = hit_en | fill_en | tmo_en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            gnt_reg      <= 1'b0;
            last_reg     <= 1'b1;
            mem_addr_reg <= 20'd0;
            mem_req_reg  <= 1'b0;
            cnt_reg      <= 8'd0;
        end else begin
            state_reg <= state_next;
            if (grant_en) begin
                gnt_reg      <= gnt_next;
                mem_addr_reg <= addr_vec[gnt_next];
            end
            if (state_reg == DONE) begin
                last_reg <= gnt_reg;
            end
            if (miss_en) begin
                mem_req_reg <= 1'b1;
                cnt_reg     <= 8'd0;
            end else if (fill_en || tmo_en) begin
                mem_req_reg <= 1'b0;
            end else if (state_reg == WAIT) begin
                cnt_reg <= cnt_reg + 8'd1;
            end
        end
    end

    // Per-port result registers and one-word cache. Only the granted port's
    // registers ever change; inv reaches both valid bits and wins over a fill.
    genvar gi;
    for (gi = 0; gi < 2; gi++) begin : g_port
        localparam logic PORT_ID = (gi == 1);

        logic        port_sel;
        logic        valid_reg;
        logic        ack_reg;
        logic        err_reg;
        logic [18:0] tag_reg;
        logic [15:0] cdata_reg;
        logic [15:0] rdata_reg;

        assign port_sel = (gnt_reg == PORT_ID);

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                valid_reg <= 1'b0;
                ack_reg   <= 1'b0;
                err_reg   <= 1'b0;
                tag_reg   <= 19'd0;
                cdata_reg <= 16'd0;
                rdata_reg <= 16'd0;
            end else begin
                ack_reg <= done_en && port_sel;
                if (done_en && port_sel) begin
                    err_reg <= tmo_en;
                    if (hit_en) begin
                        rdata_reg <= cdata_reg;
                    end else if (fill_en) begin
                        rdata_reg <= mem_rdata;
                    end else begin
                        rdata_reg <= BUSFREE;
                    end
                end
                if (fill_en && port_sel) begin
                    tag_reg   <= mem_addr_reg[19:1];
                    cdata_reg <= mem_rdata;
                end
                if (inv) begin
                    valid_reg <= 1'b0;
                end else if (fill_en && port_sel) begin
                    valid_reg <= 1'b1;
                end
            end
        end

        assign valid_vec[gi] = valid_reg;
        assign ack_vec[gi]   = ack_reg;
        assign err_vec[gi]   = err_reg;
        assign tag_vec[gi]   = tag_reg;
        assign cdata_vec[gi] = cdata_reg;
        assign rdata_vec[gi] = rdata_reg;
    end

    assign ack0     = ack_vec[0];
    assign ack1     = ack_vec[1];
    assign err0     = err_vec[0];
    assign err1     = err_vec[1];
    assign rdata0   = rdata_vec[0];
    assign rdata1   = rdata_vec[1];
    assign mem_req  = mem_req_reg;
    assign mem_addr = mem_addr_reg;
    assign busy     = (state_reg != IDLE);

endmodule

// File: tb/tb_fdc_mem_arb.sv
// -----------------------------------------------------------------------------
// tb_fdc_mem_arb
//
// Directed bench for fdc_mem_arb. Two instances:
//   dut     round-robin, TMO_CYC = 8
//   dut_fp  fixed priority, TMO_CYC = 8
// Single-port transactions come from a vector table; round-robin, fixed
// priority and reset-during-WAIT are written out as explicit sequences.
// -----------------------------------------------------------------------------
module tb_fdc_mem_arb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req0, req1, inv, mem_ack;
    logic [19:0] addr0, addr1;
    logic [15:0] mem_rdata;
    logic        ack0, ack1, err0, err1, mem_req, busy;
    logic [15:0] rdata0, rdata1;
    logic [19:0] mem_addr;

    logic        req0_f, req1_f, inv_f, mem_ack_f;
    logic [19:0] addr0_f, addr1_f;
    logic [15:0] mem_rdata_f;
    logic        ack0_f, ack1_f, err0_f, err1_f, mem_req_f, busy_f;
    logic [15:0] rdata0_f, rdata1_f;
    logic [19:0] mem_addr_f;

    fdc_mem_arb #(.FIXED_PRI(1'b0), .TMO_CYC(8'd8), .BUSFREE(16'hFFFF)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .addr0(addr0), .ack0(ack0), .rdata0(rdata0), .err0(err0),
        .req1(req1), .addr1(addr1), .ack1(ack1), .rdata1(rdata1), .err1(err1),
        .inv(inv), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .busy(busy)
    );

    fdc_mem_arb #(.FIXED_PRI(1'b1), .TMO_CYC(8'd8), .BUSFREE(16'hFFFF)) dut_fp (
        .clk(clk), .rst(rst),
        .req0(req0_f), .addr0(addr0_f), .ack0(ack0_f), .rdata0(rdata0_f), .err0(err0_f),
        .req1(req1_f), .addr1(addr1_f), .ack1(ack1_f), .rdata1(rdata1_f), .err1(err1_f),
        .inv(inv_f), .mem_req(mem_req_f), .mem_addr(mem_addr_f),
        .mem_rdata(mem_rdata_f), .mem_ack(mem_ack_f), .busy(busy_f)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [15:0] shadow [2];

    // pre: 0 none, 1 inv pulse before request, 2 inv together with the fill
    // mem_ack, 3 stray mem_ack while idle before request.
    // ack_dly: mem_req-high cycles before mem_ack; -1 = never acknowledge.
    typedef struct {
        int          port;
        logic [19:0] addr;
        int          pre;
        int          ack_dly;
        logic [15:0] md;
        int          exp_lat;
        int          exp_mreq;
        logic [15:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        int          lat;
        int          mreq_cyc;
        bit          got;
        bit          wrong;
        logic [15:0] rd;
        logic [15:0] other_rd;
        logic        er;
        lat = 0; mreq_cyc = 0; got = 0; wrong = 0; rd = '0; other_rd = '0; er = 1'b0;

        if (v.pre == 1) begin
            inv = 1'b1; tick(); inv = 1'b0;
        end
        if (v.pre == 3) begin
            mem_ack = 1'b1; mem_rdata = 16'hDEAD; tick();
            mem_ack = 1'b0; tick();
            check({tag, "_stray_idle"}, 32'({ack1, ack0, busy}), 32'd0);
            check({tag, "_stray_rdata"}, 32'(rdata0), 32'(shadow[0]));
        end

        if (v.port == 0) begin req0 = 1'b1; addr0 = v.addr; end
        else begin req1 = 1'b1; addr1 = v.addr; end

        for (int c = 0; c < 64 && !got; c++) begin
            tick();
            lat++;
            mem_ack = 1'b0;
            inv     = 1'b0;
            if (ack0 || ack1) begin
                got      = 1;
                wrong    = (v.port == 0) ? (ack1 || !ack0) : (ack0 || !ack1);
                rd       = (v.port == 0) ? rdata0 : rdata1;
                er       = (v.port == 0) ? err0 : err1;
                other_rd = (v.port == 0) ? rdata1 : rdata0;
                req0 = 1'b0; req1 = 1'b0;
            end else if (mem_req) begin
                if (mreq_cyc == v.ack_dly) begin
                    mem_ack   = 1'b1;
                    mem_rdata = v.md;
                    if (v.pre == 2) inv = 1'b1;
                end
                mreq_cyc++;
            end
        end
        req0 = 1'b0; req1 = 1'b0; mem_ack = 1'b0; inv = 1'b0;
        tick();

        $display("txn %s port=%0d addr=%h lat=%0d mem_req_cycles=%0d rdata=%h err=%b",
                 tag, v.port, v.addr, lat, mreq_cyc, rd, er);
        check({tag, "_got_ack"},   32'(got),      32'd1);
        check({tag, "_ack_port"},  32'(wrong),    32'd0);
        check({tag, "_latency"},   32'(lat),      32'(v.exp_lat));
        check({tag, "_mem_req"},   32'(mreq_cyc), 32'(v.exp_mreq));
        check({tag, "_rdata"},     32'(rd),       32'(v.exp_rd));
        check({tag, "_err"},       32'(er),       32'(v.exp_err));
        check({tag, "_other_rd"},  32'(other_rd), 32'(shadow[1 - v.port]));
        check({tag, "_ack_pulse"}, 32'({ack1, ack0, busy}), 32'd0);
        shadow[v.port] = v.exp_rd;
    endtask

    initial begin
        int          order [4];
        int          when  [4];
        logic [15:0] rdv   [4];
        int          nack;
        int          n0;
        int          n1_early;
        bit          got1;
        bit          saw_ack;
        bit          saw_req;
        vec_t        v;

        rst = 1'b1;
        req0 = 0; req1 = 0; addr0 = '0; addr1 = '0; inv = 0; mem_ack = 0; mem_rdata = '0;
        req0_f = 0; req1_f = 0; addr0_f = '0; addr1_f = '0; inv_f = 0; mem_ack_f = 0; mem_rdata_f = '0;
        shadow[0] = 16'h0000; shadow[1] = 16'h0000;

        //          port addr       pre dly  md        lat mreq rdata     err
        vecs[0]  = '{0, 20'h00100, 0,  2, 16'hA55A,  5, 3, 16'hA55A, 1'b0};
        vecs[1]  = '{0, 20'h00101, 0,  0, 16'h0000,  2, 0, 16'hA55A, 1'b0};
        vecs[2]  = '{1, 20'h00300, 0,  0, 16'h1234,  3, 1, 16'h1234, 1'b0};
        vecs[3]  = '{1, 20'h00301, 0,  0, 16'h0000,  2, 0, 16'h1234, 1'b0};
        vecs[4]  = '{0, 20'h00100, 0,  0, 16'h0000,  2, 0, 16'hA55A, 1'b0};
        vecs[5]  = '{1, 20'h00400, 0, -1, 16'h0000, 10, 8, 16'hFFFF, 1'b1};
        vecs[6]  = '{1, 20'h00401, 0, -1, 16'h0000, 10, 8, 16'hFFFF, 1'b1};
        vecs[7]  = '{1, 20'h00300, 0,  0, 16'h0000,  2, 0, 16'h1234, 1'b0};
        vecs[8]  = '{0, 20'h00200, 0,  1, 16'hBEEF,  4, 2, 16'hBEEF, 1'b0};
        vecs[9]  = '{0, 20'h00201, 1,  0, 16'hC0DE,  3, 1, 16'hC0DE, 1'b0};
        vecs[10] = '{0, 20'h00500, 2,  1, 16'h1111,  4, 2, 16'h1111, 1'b0};
        vecs[11] = '{0, 20'h00501, 0,  0, 16'h2222,  3, 1, 16'h2222, 1'b0};
        vecs[12] = '{0, 20'h00500, 3,  0, 16'h0000,  2, 0, 16'h2222, 1'b0};
        vecs[13] = '{0, 20'h00102, 0,  4, 16'h7777,  7, 5, 16'h7777, 1'b0};

        // Reset state
        tick(); tick();
        check("rst_acks",    32'({ack1, ack0, err1, err0}), 32'd0);
        check("rst_rdata0",  32'(rdata0),   32'd0);
        check("rst_rdata1",  32'(rdata1),   32'd0);
        check("rst_mem_req", 32'(mem_req),  32'd0);
        check("rst_mem_addr",32'(mem_addr), 32'd0);
        check("rst_busy",    32'(busy),     32'd0);
        check("rst_fp_idle", 32'({ack1_f, ack0_f, mem_req_f, busy_f}), 32'd0);
        rst = 1'b0;
        tick();

        // Table of single-port transactions
        for (int i = 0; i < 14; i++) begin
            run_vec($sformatf("v%0d", i), vecs[i]);
        end

        // Reset during WAIT: fill 00800, then abandon a miss at 00900
        v = '{0, 20'h00800, 0, 0, 16'h3333, 3, 1, 16'h3333, 1'b0};
        run_vec("rw_fill", v);
        req0 = 1'b1; addr0 = 20'h00900;
        saw_req = 0;
        for (int c = 0; c < 20 && !saw_req; c++) begin
            tick();
            saw_req = mem_req;
        end
        check("rw_mem_req_up", 32'(saw_req), 32'd1);
        tick(); tick();
        #2 rst = 1'b1;
        #1;
        check("rw_mem_req_drop", 32'(mem_req), 32'd0);
        check("rw_busy_drop",    32'(busy),    32'd0);
        req0 = 1'b0;
        tick();
        rst = 1'b0;
        saw_ack = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (ack0 || ack1) saw_ack = 1;
        end
        check("rw_no_ack",  32'(saw_ack), 32'd0);
        check("rw_rdata0",  32'(rdata0),  32'd0);
        shadow[0] = 16'h0000; shadow[1] = 16'h0000;
        $display("txn rw_abort port=0 addr=00900 aborted by reset");
        v = '{0, 20'h00801, 0, 0, 16'h4444, 3, 1, 16'h4444, 1'b0};
        run_vec("rw_after", v);

        // Round-robin from a fresh reset; both ports held high
        rst = 1'b1; tick(); rst = 1'b0; tick();
        nack = 0;
        addr0 = 20'h00600; addr1 = 20'h00700; req0 = 1'b1; req1 = 1'b1;
        for (int c = 0; c < 60 && nack < 4; c++) begin
            tick();
            mem_ack = 1'b0;
            if (ack0 || ack1) begin
                order[nack] = ack1 ? 1 : 0;
                rdv[nack]   = ack1 ? rdata1 : rdata0;
                when[nack]  = c;
                $display("txn rr%0d port=%0d rdata=%h cycle=%0d", nack, order[nack], rdv[nack], c);
                nack++;
                if (nack == 4) begin req0 = 1'b0; req1 = 1'b0; end
            end else if (mem_req) begin
                mem_ack   = 1'b1;
                mem_rdata = mem_addr[15:0] ^ 16'h5A5A;
            end
        end
        req0 = 1'b0; req1 = 1'b0; mem_ack = 1'b0;
        tick(); tick();
        check("rr_count", 32'(nack), 32'd4);
        if (nack == 4) begin
            for (int i = 0; i < 4; i++) begin
                check($sformatf("rr_order%0d", i), 32'(order[i]), 32'(i % 2));
                check($sformatf("rr_rdata%0d", i), 32'(rdv[i]),
                      32'((i % 2 == 0) ? (16'h0600 ^ 16'h5A5A) : (16'h0700 ^ 16'h5A5A)));
            end
            check("rr_miss_gap", 32'(when[1] - when[0]), 32'd4);
            check("rr_hit_gap",  32'(when[3] - when[2]), 32'd3);
        end

        // Fixed priority: req1 held, req0 re-raised after each ack0
        n0 = 0; n1_early = 0; got1 = 0;
        addr0_f = 20'h00A00; addr1_f = 20'h00B00; req0_f = 1'b1; req1_f = 1'b1;
        for (int c = 0; c < 80 && !got1; c++) begin
            tick();
            mem_ack_f = 1'b0;
            if (ack1_f) begin
                if (n0 < 3) n1_early++;
                got1 = 1;
                req1_f = 1'b0;
                $display("txn fp port=1 rdata=%h cycle=%0d", rdata1_f, c);
            end
            if (ack0_f) begin
                n0++;
                req0_f = 1'b0;
                $display("txn fp port=0 rdata=%h cycle=%0d", rdata0_f, c);
            end else begin
                req0_f = (n0 < 3);
            end
            if (mem_req_f) begin
                mem_ack_f   = 1'b1;
                mem_rdata_f = 16'h0F0F;
            end
        end
        req0_f = 1'b0; req1_f = 1'b0; mem_ack_f = 1'b0;
        tick();
        check("fp_port0_acks", 32'(n0),        32'd3);
        check("fp_port1_early",32'(n1_early),  32'd0);
        check("fp_port1_done", 32'(got1),      32'd1);
        check("fp_rdata1",     32'(rdata1_f),  32'h0F0F);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
